// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM request and the IF->ID bus.
// Latency: one clock from an advancing cycle to the new address on inst_sram_addr / if_to_id_bus.
// Backpressure: stall[0] freezes pc_reg/ce_reg; a redirect seen while frozen is parked and used on release.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset (dominant over every other input)
//   stall[5:0]        pipeline stall vector, only stall[0] (PC/IF hold) is used here
//   br_bus[32:0]      {br_e, br_addr} from ID, combinational in ID
//   if_to_id_bus      {ce, pc} towards ID
//   inst_sram_*       fetch request; the stage never writes, so wen/wdata are tied to zero
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic [32:0] br_bus,
   output logic [32:0] if_to_id_bus,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_wen,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata
);

   typedef enum logic [1:0] {
      BOOT      = 2'd0,
      RUN       = 2'd1,
      HOLD_PEND = 2'd2
   } state_t;

   typedef struct packed {
      logic        ce;
      logic [31:0] pc;
   } if_to_id_t;

   typedef struct packed {
      logic        br_e;
      logic [31:0] br_addr;
   } br_t;

   state_t      state, state_nxt;
   logic [31:0] pc_reg, pc_nxt;
   logic        ce_reg, ce_nxt;
   logic        pend_valid, pend_valid_nxt;
   logic [31:0] pend_addr, pend_addr_nxt;

   br_t         br;
   logic        hold;
   logic [31:0] next_pc;
   if_to_id_t   to_id;

   // Only stall[0] concerns the fetch stage; the other bits belong to later stages.
   logic        unused_stall_hi;
   assign unused_stall_hi = ^stall[5:1];

   assign br   = br_t'(br_bus);
   assign hold = stall[0];

   // A fresh redirect beats a parked one; otherwise fall through sequentially (wraps at 2^32).
   always_comb begin
      next_pc = pc_reg + 32'd4;
      if (br.br_e) begin
         next_pc = br.br_addr;
      end else if (pend_valid) begin
         next_pc = pend_addr;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc_reg;
      ce_nxt         = ce_reg;
      pend_valid_nxt = pend_valid;
      pend_addr_nxt  = pend_addr;

      if (!hold) begin
         pc_nxt         = next_pc;
         ce_nxt         = 1'b1;
         pend_valid_nxt = 1'b0;
      end else if (br.br_e) begin
         // PC must stay put for the SRAM, so park the target; newest redirect wins.
         pend_valid_nxt = 1'b1;
         pend_addr_nxt  = br.br_addr;
      end

      case (state)
         BOOT: begin
            if (!hold) state_nxt = RUN;
         end
         RUN: begin
            if (hold && br.br_e) state_nxt = HOLD_PEND;
         end
         HOLD_PEND: begin
            if (!hold) state_nxt = RUN;
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BOOT;
         pc_reg     <= RESET_PC;
         ce_reg     <= 1'b0;
         pend_valid <= 1'b0;
         pend_addr  <= 32'd0;
      end else begin
         state      <= state_nxt;
         pc_reg     <= pc_nxt;
         ce_reg     <= ce_nxt;
         pend_valid <= pend_valid_nxt;
         pend_addr  <= pend_addr_nxt;
      end
   end

   // Outputs come straight from registers: no combinational path from stall or br_bus.
   assign to_id.ce        = ce_reg;
   assign to_id.pc        = pc_reg;
   assign if_to_id_bus    = to_id;
   assign inst_sram_en    = ce_reg;
   assign inst_sram_addr  = pc_reg;
   assign inst_sram_wen   = 4'b0000;
   assign inst_sram_wdata = 32'd0;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline and the producer side of the IF→ID interface.
- Owns the PC register and drives the instruction SRAM request.
- Emits if_to_id_bus {ce, pc} and consumes the branch-redirect bus br_bus {br_e, br_addr} returned by ID.
- Buffers any redirect that arrives while the PC is stalled, so a taken branch is never lost.

Parameters:
- RESET_PC, 32'hBFBF_FFFC: PC value held in reset. The first fetched address is RESET_PC+4 = 32'hBFC0_0000.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- stall  input  `StallBus (6)  pipeline stall vector; stall[0] = PC/IF hold, `Stop = 1
- br_bus  input  `BR_WD (33)  {br_e[32], br_addr[31:0]} from ID, combinational in ID
- if_to_id_bus  output  `IF_TO_ID_WD (33)  {ce[32], pc[31:0]}
- inst_sram_en  output  1  fetch enable
- inst_sram_wen  output  4  byte write enables, constant 4'b0000
- inst_sram_addr  output  32  fetch address
- inst_sram_wdata  output  32  constant 32'b0

Behaviour:
- Registers:
  - pc_reg[31:0], ce_reg, pend_valid, pend_addr[31:0].
  - State register: BOOT, RUN, HOLD_PEND.
- Outputs are pure functions of the registers (no comb path from stall or br_bus):
  - if_to_id_bus = {ce_reg, pc_reg}
  - inst_sram_en = ce_reg
  - inst_sram_addr = pc_reg
  - inst_sram_wen = 0, inst_sram_wdata = 0
- Reset (rst=1 at posedge), dominant over every other input:
  - pc_reg=RESET_PC, ce_reg=0, pend_valid=0, pend_addr=0, state=BOOT.
  - Visible outputs during reset: en=0, bus={0, 32'hBFBF_FFFC}.
- next_pc priority:
  1. br_e → br_addr
  2. else pend_valid → pend_addr
  3. else pc_reg+4, 32-bit wrap (32'hFFFF_FFFC+4 = 0)
- Advance (stall[0]==0): pc_reg<=next_pc, ce_reg<=1, pend_valid<=0.
- Hold (stall[0]==1): pc_reg and ce_reg unchanged, so the SRAM address stays stable.
  - If br_e=1: pend_valid<=1, pend_addr<=br_addr. The latest redirect overwrites any older pending one.
- State transitions:
  - BOOT → RUN on the first advance; BOOT stays BOOT while stalled. ce=0 throughout BOOT.
  - RUN → HOLD_PEND on hold with br_e=1; otherwise RUN.
  - HOLD_PEND → RUN on advance, which consumes the pending target or a fresh br_e.
  - HOLD_PEND stays HOLD_PEND while stalled, updating pend_addr if br_e=1.
- Redirect semantics:
  - br_e is sampled in the same cycle ID decodes the branch. The delay-slot instruction (pc+4) has already been requested.
  - The redirect therefore becomes the PC one cycle after the branch is in ID.
  - br_addr is used verbatim; no alignment check.
- Simultaneous events:
  - br_e with pend_valid on an advance: br_e wins and pend is cleared.
  - rst with anything: reset wins.
- Reset mid-operation clears any pending redirect; fetch restarts at BFC0_0000 after release.
- Latency:
  - One clock from advance to new address on inst_sram_addr.
  - Instruction data returns next cycle and is consumed by ID.

Test Plan:
- Boot: rst=1 for 3 cycles, then rst=0, stall=0.
  - During reset: en=0, pc=BFBF_FFFC.
  - Cycle 1 after release: en=1, addr=BFC0_0000, ce=1.
  - Cycle 2: BFC0_0004. Cycle 3: BFC0_0008.
- Redirect: at pc=BFC0_0008, pulse br_bus={1, 32'hBFC0_0100} for one cycle with stall=0 → next addr=BFC0_0100, then BFC0_0104.
- Stall hold: at pc=BFC0_0010, drive stall[0]=1 for 4 cycles → addr held at BFC0_0010, en=1; on release → BFC0_0014.
- Redirect during stall: stall[0]=1 and br_e=1, br_addr=BFC0_0200 for one cycle, then br_e=0 with stall held 2 more cycles → addr unchanged while stalled, state=HOLD_PEND; on release addr=BFC0_0200.
- Overwrite and priority during stall:
  - br_addr=BFC0_0300 then BFC0_0400 while stalled → on release addr=BFC0_0400.
  - Repeat with pending BFC0_0500 and br_e=1/BFC0_0600 in the release cycle → addr=BFC0_0600.
- Reset mid-op: pending redirect to BFC0_0700 with stall held, assert rst=1 for 1 cycle → en=0, pend cleared; after release addr=BFC0_0000, never 0700.
